// File: rtl/lane_pipe_pkg.sv
// ============================================================================
// Module      : lane_pipe_pkg
// Description : Shared constants, lane typedefs and occupancy-width helper
//               for the lane_pipe_array elastic pipe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lane_pipe_pkg;

    localparam int c_NUM_LANES_DEF = 6;
    localparam int c_LANE_W_DEF    = 2;
    localparam int c_DEPTH_DEF     = 4;

    typedef logic [c_LANE_W_DEF-1:0] lane_t;
    typedef lane_t [c_NUM_LANES_DEF-1:0] lane_vec_t;

    // Width needed to count 0..depth valid stages inclusive.
    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/lane_pipe_array_pipe_stage.sv
// ============================================================================
// Module      : pipe_stage
// Description : One elastic register slice: valid/data registers, load when
//               empty or downstream ready, flush clears valid only.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage
    import lane_pipe_pkg::*;
#(
    parameter int W = c_NUM_LANES_DEF * c_LANE_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    input  logic         up_valid_i,
    input  logic [W-1:0] up_data_i,
    input  logic         dn_ready_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         r_v_q;
    logic         w_v_d;
    logic [W-1:0] r_data_q;
    logic [W-1:0] w_data_d;
    logic         w_ready;

    assign w_ready = ~r_v_q | dn_ready_i;

    // Data only captures real beats so bubbles never toggle the register.
    always_comb begin
        w_v_d    = r_v_q;
        w_data_d = r_data_q;
        if (flush_i) begin
            w_v_d = 1'b0;
        end else if (w_ready) begin
            w_v_d = up_valid_i;
            if (up_valid_i) begin
                w_data_d = up_data_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v_q    <= 1'b0;
            r_data_q <= '0;
        end else begin
            r_v_q    <= w_v_d;
            r_data_q <= w_data_d;
        end
    end

    assign valid_o = r_v_q;
    assign data_o  = r_data_q;

endmodule

`default_nettype wire

// File: rtl/lane_pipe_array.sv
// ============================================================================
// Module      : lane_pipe_array
// Description : NUM_LANES x LANE_W lockstep elastic pipe, DEPTH stages deep,
//               with flush and busy. Define LANE_PIPE_OCC_EN to add occ.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lane_pipe_array
    import lane_pipe_pkg::*;
#(
    parameter int NUM_LANES = c_NUM_LANES_DEF,
    parameter int LANE_W    = c_LANE_W_DEF,
    parameter int DEPTH     = c_DEPTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NUM_LANES*LANE_W-1:0] in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NUM_LANES*LANE_W-1:0] out_data,
    output logic                        busy
`ifdef LANE_PIPE_OCC_EN
    ,
    output logic [occ_w(DEPTH)-1:0]     occ
`endif
);

    localparam int c_DATA_W = NUM_LANES * LANE_W;

    logic [DEPTH-1:0]    w_valid;
    logic [c_DATA_W-1:0] w_data [DEPTH];
    logic [DEPTH:0]      w_rdy;

    // Ready chain unrolled: stage k can move if any stage at or after k is
    // empty, or the consumer is taking a beat.
    always_comb begin
        w_rdy = '0;
        for (int k = 0; k <= DEPTH; k++) begin
            w_rdy[k] = out_ready;
            for (int j = k; j < DEPTH; j++) begin
                if (!w_valid[j]) begin
                    w_rdy[k] = 1'b1;
                end
            end
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic                w_up_valid;
        logic [c_DATA_W-1:0] w_up_data;

        if (k == 0) begin : g_head
            assign w_up_valid = in_valid;
            assign w_up_data  = in_data;
        end else begin : g_body
            assign w_up_valid = w_valid[k-1];
            assign w_up_data  = w_data[k-1];
        end

        pipe_stage #(
            .W (c_DATA_W)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .flush_i    (flush),
            .up_valid_i (w_up_valid),
            .up_data_i  (w_up_data),
            .dn_ready_i (w_rdy[k+1]),
            .valid_o    (w_valid[k]),
            .data_o     (w_data[k])
        );
    end

    assign in_ready  = w_rdy[0] & ~flush;
    assign out_valid = w_valid[DEPTH-1];
    assign out_data  = w_data[DEPTH-1];
    assign busy      = |w_valid;

`ifdef LANE_PIPE_OCC_EN
    localparam int c_OCC_W = occ_w(DEPTH);

    logic [c_OCC_W-1:0] r_occ_q;
    logic [c_OCC_W-1:0] w_occ_d;
    logic               w_acc;
    logic               w_emit;

    always_comb begin
        w_acc   = in_valid & in_ready;
        w_emit  = out_valid & out_ready;
        w_occ_d = r_occ_q;
        if (flush) begin
            w_occ_d = '0;
        end else if (w_acc && !w_emit) begin
            w_occ_d = r_occ_q + 1'b1;
        end else if (!w_acc && w_emit) begin
            w_occ_d = r_occ_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ_q <= '0;
        end else begin
            r_occ_q <= w_occ_d;
        end
    end

    assign occ = r_occ_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lane_pipe_array.sv
// ============================================================================
// Module      : tb_lane_pipe_array
// Description : Self-checking bench for lane_pipe_array (default 6x2, depth 4);
//               checks occ too when LANE_PIPE_OCC_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lane_pipe_array;

    localparam int NL    = 6;
    localparam int LW    = 2;
    localparam int DEPTH = 4;
    localparam int DW    = NL * LW;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          busy;
`ifdef LANE_PIPE_OCC_EN
    logic [2:0]    occ;
`endif

    int n_vec = 0;
    int n_err = 0;

    lane_pipe_array #(
        .NUM_LANES (NL),
        .LANE_W    (LW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
`ifdef LANE_PIPE_OCC_EN
        ,
        .occ       (occ)
`endif
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_vec++; if (out_data !== 12'h000) begin n_err++; $display("FAIL reset_out_data: got %h expected 000", out_data); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
`ifdef LANE_PIPE_OCC_EN
        n_vec++; if (occ !== 3'd0) begin n_err++; $display("FAIL reset_occ: got %0d expected 0", occ); end
`endif
        next_cycle();
    endtask

    task automatic test_streaming();
        logic [DW-1:0] vals [4];
        vals[0] = 12'hA5C; vals[1] = 12'h3F1; vals[2] = 12'h000; vals[3] = 12'hFFF;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = (i < 4);
            in_data  = '0;
            if (i < 4) in_data = vals[i];
            @(negedge clk);
            if (i < 4) begin
                n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream_early_valid: cycle %0d got %b expected 0", i, out_valid); end
                n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream_in_ready: cycle %0d got %b expected 1", i, in_ready); end
            end else begin
                n_vec++;
                if (out_valid !== 1'b1 || out_data !== vals[i-4]) begin
                    n_err++;
                    $display("FAIL stream_out: cycle %0d got valid=%b data=%h expected valid=1 data=%h", i, out_valid, out_data, vals[i-4]);
                end
            end
            next_cycle();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] vals [5];
        int  got;
        bit  acc_now;
        for (int i = 0; i < 5; i++) vals[i] = DW'($urandom);
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = vals[i];
            @(negedge clk);
            n_vec++;
            if (in_ready !== (i < 4)) begin n_err++; $display("FAIL bp_in_ready: beat %0d got %b expected %b", i, in_ready, (i < 4)); end
            if (i == 4) begin
                n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL bp_busy: got %b expected 1", busy); end
                n_vec++;
                if (out_valid !== 1'b1 || out_data !== vals[0]) begin
                    n_err++; $display("FAIL bp_head: got valid=%b data=%h expected valid=1 data=%h", out_valid, out_data, vals[0]);
                end
`ifdef LANE_PIPE_OCC_EN
                n_vec++; if (occ !== 3'd4) begin n_err++; $display("FAIL bp_occ: got %0d expected 4", occ); end
`endif
            end
            if (i < 4) next_cycle();
        end
        next_cycle();
        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 0) begin
                n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_fifth_accept: got %b expected 1", in_ready); end
            end
            if (out_valid) begin
                n_vec++;
                if (got >= 5) begin
                    n_err++; $display("FAIL bp_extra_beat: got data=%h expected no beat", out_data);
                end else if (out_data !== vals[got]) begin
                    n_err++; $display("FAIL bp_drain_order: beat %0d got %h expected %h", got, out_data, vals[got]);
                end
                got++;
            end
            acc_now = in_valid && in_ready;
            next_cycle();
            if (acc_now) in_valid = 1'b0;
        end
        n_vec++; if (got != 5) begin n_err++; $display("FAIL bp_drain_count: got %0d expected 5", got); end
    endtask

    task automatic test_bubble_collapse();
        logic [DW-1:0] vals [4];
        int idx;
        int got;
        for (int i = 0; i < 4; i++) vals[i] = DW'($urandom);
        do_reset();
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 9; c++) begin
            in_valid = (c == 0 || c == 3 || c == 5 || c == 8);
            in_data  = '0;
            if (in_valid) in_data = vals[idx];
            @(negedge clk);
            if (in_valid) begin
                n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bubble_accept: beat %0d got %b expected 1", idx, in_ready); end
                idx++;
            end
            next_cycle();
        end
        in_valid = 1'b1;
        in_data  = DW'($urandom);
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bubble_full_ready: got %b expected 0", in_ready); end
        n_vec++; if (out_valid !== 1'b1 || out_data !== vals[0]) begin n_err++; $display("FAIL bubble_head: got valid=%b data=%h expected valid=1 data=%h", out_valid, out_data, vals[0]); end
`ifdef LANE_PIPE_OCC_EN
        n_vec++; if (occ !== 3'd4) begin n_err++; $display("FAIL bubble_occ: got %0d expected 4", occ); end
`endif
        next_cycle();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out_valid) begin
                n_vec++;
                if (got >= 4) begin
                    n_err++; $display("FAIL bubble_extra_beat: got data=%h expected no beat", out_data);
                end else if (out_data !== vals[got]) begin
                    n_err++; $display("FAIL bubble_order: beat %0d got %h expected %h", got, out_data, vals[got]);
                end
                got++;
            end
            next_cycle();
        end
        n_vec++; if (got != 4) begin n_err++; $display("FAIL bubble_count: got %0d expected 4", got); end
    endtask

    task automatic test_flush();
        logic [DW-1:0] nb;
        int got;
        do_reset();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            in_data  = DW'($urandom);
            next_cycle();
        end
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = DW'($urandom);
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_in_ready: got %b expected 0", in_ready); end
        next_cycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_out_valid: got %b expected 0", out_valid); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_busy: got %b expected 0", busy); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_ready_after: got %b expected 1", in_ready); end
`ifdef LANE_PIPE_OCC_EN
        n_vec++; if (occ !== 3'd0) begin n_err++; $display("FAIL flush_occ: got %0d expected 0", occ); end
`endif
        next_cycle();
        nb        = DW'($urandom);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = nb;
        got = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid) begin
                n_vec++;
                if (c != DEPTH || out_data !== nb) begin
                    n_err++; $display("FAIL flush_after_beat: cycle %0d got %h expected %h at cycle %0d", c, out_data, nb, DEPTH);
                end
                got++;
            end
            next_cycle();
            in_valid = 1'b0;
        end
        n_vec++; if (got != 1) begin n_err++; $display("FAIL flush_after_count: got %0d expected 1", got); end
    endtask

    task automatic test_rst_priority();
        do_reset();
        out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            in_valid = 1'b1;
            in_data  = DW'($urandom) | 12'h001;
            next_cycle();
        end
        rst      = 1'b1;
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 12'hFFF;
        next_cycle();
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstpri_out_valid: got %b expected 0", out_valid); end
        n_vec++; if (out_data !== 12'h000) begin n_err++; $display("FAIL rstpri_out_data: got %h expected 000", out_data); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstpri_busy: got %b expected 0", busy); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rstpri_in_ready: got %b expected 1", in_ready); end
`ifdef LANE_PIPE_OCC_EN
        n_vec++; if (occ !== 3'd0) begin n_err++; $display("FAIL rstpri_occ: got %0d expected 0", occ); end
`endif
        next_cycle();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstpri_no_emit: cycle %0d got %b expected 0", c, out_valid); end
            next_cycle();
        end
    endtask

    // Reference: a FIFO of in-flight beats bounded by DEPTH. A beat is taken
    // whenever there is room or the consumer is draining this cycle.
    task automatic test_random();
        logic [DW-1:0] q [$];
        logic [DW-1:0] prev_data;
        logic [DW-1:0] exp_d;
        bit            prev_stall;
        bit            exp_rdy;
        do_reset();
        prev_stall = 1'b0;
        prev_data  = '0;
        for (int n = 0; n < 600; n++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = DW'($urandom);
            @(negedge clk);
            exp_rdy = (q.size() < DEPTH) || out_ready;
            n_vec++; if (in_ready !== exp_rdy) begin n_err++; $display("FAIL rand_in_ready: step %0d got %b expected %b", n, in_ready, exp_rdy); end
            n_vec++; if (busy !== (q.size() != 0)) begin n_err++; $display("FAIL rand_busy: step %0d got %b expected %b", n, busy, (q.size() != 0)); end
`ifdef LANE_PIPE_OCC_EN
            n_vec++; if (int'(occ) != q.size()) begin n_err++; $display("FAIL rand_occ: step %0d got %0d expected %0d", n, occ, q.size()); end
`endif
            if (prev_stall) begin
                n_vec++;
                if (out_valid !== 1'b1 || out_data !== prev_data) begin
                    n_err++; $display("FAIL rand_stall_hold: step %0d got valid=%b data=%h expected valid=1 data=%h", n, out_valid, out_data, prev_data);
                end
            end
            if (out_valid) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_err++; $display("FAIL rand_spurious: step %0d got data=%h expected no beat", n, out_data);
                end else if (out_ready) begin
                    exp_d = q.pop_front();
                    if (out_data !== exp_d) begin n_err++; $display("FAIL rand_data: step %0d got %h expected %h", n, out_data, exp_d); end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (in_valid && exp_rdy) q.push_back(in_data);
            next_cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 40 && q.size() != 0; c++) begin
            @(negedge clk);
            if (out_valid) begin
                n_vec++;
                exp_d = q.pop_front();
                if (out_data !== exp_d) begin n_err++; $display("FAIL rand_drain: got %h expected %h", out_data, exp_d); end
            end
            next_cycle();
        end
        n_vec++; if (q.size() != 0) begin n_err++; $display("FAIL rand_leftover: got %0d beats stuck expected 0", q.size()); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_bubble_collapse();
        test_flush();
        test_rst_priority();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
